l09_updown_counter: RTL and testbench

//   Parametrised up/down modulo-N counter. Successor to the fixed 2-bit mod-3 up counter.

---
 rtl/l09_updown_counter_if.sv | 25 ++
 rtl/l09_updown_counter.sv | 107 ++++++++++
 tb/tb_l09_updown_counter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/l09_updown_counter_if.sv
// Bus bundle for l09_updown_counter: control/request inputs and registered status outputs.
// The driver of the counter holds the master modport; the counter itself holds the slave modport.
interface l09_updown_counter_if #(
    parameter int WIDTH = 2
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up;
    logic             dn;
    logic [WIDTH-1:0] count;
    logic             wrap_up;
    logic             wrap_dn;
    logic             ovf;

    modport master (
        output clr, load, load_val, up, dn,
        input  count, wrap_up, wrap_dn, ovf
    );

    modport slave (
        input  clr, load, load_val, up, dn,
        output count, wrap_up, wrap_dn, ovf
    );
endinterface

// File: rtl/l09_updown_counter.sv
// Up/down modulo-MODULO counter with clear, clamped load, wrap/saturate ends, and an optional
// rising-edge request mode. Every output comes straight from a flop.
module l09_updown_counter #(
    parameter int WIDTH     = 2,
    parameter int MODULO    = 3,
    parameter int SATURATE  = 0,
    parameter int EDGE_MODE = 0
) (
    input  logic                     clk,
    input  logic                     n_rst,
    l09_updown_counter_if.slave      bus
);
    if (MODULO < 2) begin : g_bad_modulo
        $error("l09_updown_counter: MODULO must be at least 2");
    end
    if ((2 ** WIDTH) < MODULO) begin : g_bad_width
        $error("l09_updown_counter: WIDTH too small for MODULO");
    end

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic             up_d;
    logic             dn_d;
    logic             up_q;
    logic             dn_q;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_up_r;
    logic             wrap_up_nxt;
    logic             wrap_dn_r;
    logic             wrap_dn_nxt;
    logic             ovf_r;
    logic             ovf_nxt;
    logic [WIDTH-1:0] load_clamped;

    // Edge history runs every cycle, so a request edge swallowed by clr/load is not replayed later.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            up_d <= 1'b0;
            dn_d <= 1'b0;
        end else begin
            up_d <= bus.up;
            dn_d <= bus.dn;
        end
    end

    always_comb begin
        if (EDGE_MODE != 0) begin
            up_q = bus.up & ~up_d;
            dn_q = bus.dn & ~dn_d;
        end else begin
            up_q = bus.up;
            dn_q = bus.dn;
        end
    end

    assign load_clamped = (bus.load_val > MAX_CNT) ? MAX_CNT : bus.load_val;

    always_comb begin
        count_nxt   = count_r;
        wrap_up_nxt = 1'b0;
        wrap_dn_nxt = 1'b0;
        ovf_nxt     = ovf_r;
        if (bus.clr) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (bus.load) begin
            count_nxt = load_clamped;
        end else if (up_q && !dn_q) begin
            if (count_r >= MAX_CNT) begin
                wrap_up_nxt = 1'b1;
                ovf_nxt     = 1'b1;
                count_nxt   = (SATURATE != 0) ? MAX_CNT : '0;
            end else begin
                count_nxt = count_r + ONE;
            end
        end else if (dn_q && !up_q) begin
            if (count_r == '0) begin
                wrap_dn_nxt = 1'b1;
                ovf_nxt     = 1'b1;
                count_nxt   = (SATURATE != 0) ? '0 : MAX_CNT;
            end else begin
                count_nxt = count_r - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r   <= '0;
            wrap_up_r <= 1'b0;
            wrap_dn_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            count_r   <= count_nxt;
            wrap_up_r <= wrap_up_nxt;
            wrap_dn_r <= wrap_dn_nxt;
            ovf_r     <= ovf_nxt;
        end
    end

    assign bus.count   = count_r;
    assign bus.wrap_up = wrap_up_r;
    assign bus.wrap_dn = wrap_dn_r;
    assign bus.ovf     = ovf_r;
endmodule

// File: tb/tb_l09_updown_counter.sv
// Drives four counter configurations from one stimulus stream and compares each against
// an arithmetic reference model, plus directed checks of the documented scenarios.
module tb_l09_updown_counter;
    localparam int N = 4;
    localparam int P_W [N] = '{2, 3, 2, 3};
    localparam int P_M [N] = '{3, 5, 3, 6};
    localparam int P_S [N] = '{0, 1, 0, 1};
    localparam int P_E [N] = '{0, 0, 1, 1};

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [2:0] lv = 3'd0;
    logic       up = 1'b0;
    logic       dn = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l09_updown_counter_if #(.WIDTH(2)) b0 ();
    l09_updown_counter_if #(.WIDTH(3)) b1 ();
    l09_updown_counter_if #(.WIDTH(2)) b2 ();
    l09_updown_counter_if #(.WIDTH(3)) b3 ();

    assign b0.clr = clr;  assign b0.load = load;  assign b0.load_val = lv[1:0];
    assign b0.up  = up;   assign b0.dn   = dn;
    assign b1.clr = clr;  assign b1.load = load;  assign b1.load_val = lv;
    assign b1.up  = up;   assign b1.dn   = dn;
    assign b2.clr = clr;  assign b2.load = load;  assign b2.load_val = lv[1:0];
    assign b2.up  = up;   assign b2.dn   = dn;
    assign b3.clr = clr;  assign b3.load = load;  assign b3.load_val = lv;
    assign b3.up  = up;   assign b3.dn   = dn;

    l09_updown_counter #(.WIDTH(2), .MODULO(3), .SATURATE(0), .EDGE_MODE(0)) u0 (.clk(clk), .n_rst(n_rst), .bus(b0));
    l09_updown_counter #(.WIDTH(3), .MODULO(5), .SATURATE(1), .EDGE_MODE(0)) u1 (.clk(clk), .n_rst(n_rst), .bus(b1));
    l09_updown_counter #(.WIDTH(2), .MODULO(3), .SATURATE(0), .EDGE_MODE(1)) u2 (.clk(clk), .n_rst(n_rst), .bus(b2));
    l09_updown_counter #(.WIDTH(3), .MODULO(6), .SATURATE(1), .EDGE_MODE(1)) u3 (.clk(clk), .n_rst(n_rst), .bus(b3));

    logic [2:0] obs_cnt [N];
    logic [N-1:0] obs_wu, obs_wd, obs_ovf;
    assign obs_cnt[0] = 3'(b0.count);
    assign obs_cnt[1] = b1.count;
    assign obs_cnt[2] = 3'(b2.count);
    assign obs_cnt[3] = b3.count;
    assign obs_wu  = {b3.wrap_up, b2.wrap_up, b1.wrap_up, b0.wrap_up};
    assign obs_wd  = {b3.wrap_dn, b2.wrap_dn, b1.wrap_dn, b0.wrap_dn};
    assign obs_ovf = {b3.ovf, b2.ovf, b1.ovf, b0.ovf};

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: counts held as plain integers, stepped with modular arithmetic.
    int m_cnt [N];
    int m_wu  [N];
    int m_wd  [N];
    int m_ovf [N];
    int m_upd [N];
    int m_dnd [N];

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] <= 0; m_wu[i] <= 0; m_wd[i] <= 0;
                m_ovf[i] <= 0; m_upd[i] <= 0; m_dnd[i] <= 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                automatic int c   = m_cnt[i];
                automatic int o   = m_ovf[i];
                automatic int wu  = 0;
                automatic int wd  = 0;
                automatic int top = P_M[i] - 1;
                automatic int v   = int'(lv) % (1 << P_W[i]);
                automatic bit uq  = up && (P_E[i] == 0 || m_upd[i] == 0);
                automatic bit dq  = dn && (P_E[i] == 0 || m_dnd[i] == 0);
                if (clr) begin
                    c = 0; o = 0;
                end else if (load) begin
                    c = (v > top) ? top : v;
                end else if (uq && !dq) begin
                    if (c == top) begin
                        wu = 1; o = 1;
                        if (P_S[i] == 0) c = 0;
                    end else c = c + 1;
                end else if (dq && !uq) begin
                    if (c == 0) begin
                        wd = 1; o = 1;
                        if (P_S[i] == 0) c = top;
                    end else c = c - 1;
                end
                m_cnt[i] <= c; m_wu[i] <= wu; m_wd[i] <= wd; m_ovf[i] <= o;
                m_upd[i] <= int'(up); m_dnd[i] <= int'(dn);
            end
        end
    end

    always @(negedge clk) begin
        if (n_rst) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("model_count[%0d]", i), int'(obs_cnt[i]), m_cnt[i]);
                check($sformatf("model_wrap_up[%0d]", i), int'(obs_wu[i]), m_wu[i]);
                check($sformatf("model_wrap_dn[%0d]", i), int'(obs_wd[i]), m_wd[i]);
                check($sformatf("model_ovf[%0d]", i), int'(obs_ovf[i]), m_ovf[i]);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_count[%0d]", tag, i), int'(obs_cnt[i]), 0);
            check($sformatf("%s_flags[%0d]", tag, i), int'({obs_wu[i], obs_wd[i], obs_ovf[i]}), 0);
        end
    endtask

    int exp_seq [4] = '{1, 2, 0, 1};

    initial begin
        // Reset held with up asserted, then four counting cycles on the default counter.
        up = 1'b1;
        #12;
        check_reset_state("reset");
        n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t1_count%0d", k), int'(obs_cnt[0]), exp_seq[k]);
            check($sformatf("t1_wrap_up%0d", k), int'(obs_wu[0]), (k == 2) ? 1 : 0);
        end

        // Down from 0 wraps to top, then both requests held.
        up = 1'b0; clr = 1'b1;
        @(negedge clk);
        check("t2_clr_count", int'(obs_cnt[0]), 0);
        check("t2_clr_ovf", int'(obs_ovf[0]), 0);
        clr = 1'b0; dn = 1'b1;
        @(negedge clk);
        check("t2_dn_count", int'(obs_cnt[0]), 2);
        check("t2_dn_wrap", int'(obs_wd[0]), 1);
        check("t2_dn_ovf", int'(obs_ovf[0]), 1);
        up = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_hold_count", int'(obs_cnt[0]), 2);
            check("t2_hold_pulses", int'({obs_wu[0], obs_wd[0]}), 0);
        end

        // Saturating counter pinned at its top value.
        up = 1'b0; dn = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; up = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t3_count%0d", k), int'(obs_cnt[1]), (k < 4) ? k : 4);
            check($sformatf("t3_wrap_up%0d", k), int'(obs_wu[1]), (k >= 5) ? 1 : 0);
        end
        check("t3_ovf_set", int'(obs_ovf[1]), 1);
        up = 1'b0; clr = 1'b1;
        @(negedge clk);
        check("t3_clr_count", int'(obs_cnt[1]), 0);
        check("t3_clr_ovf", int'(obs_ovf[1]), 0);

        // Load clamping and priority.
        clr = 1'b0; load = 1'b1; lv = 3'd7;
        @(negedge clk);
        check("t4_clamp", int'(obs_cnt[1]), 4);
        check("t4_clamp_w2", int'(obs_cnt[0]), 2);
        lv = 3'd2; up = 1'b1;
        @(negedge clk);
        check("t4_load_wins", int'(obs_cnt[1]), 2);
        clr = 1'b1; up = 1'b0;
        @(negedge clk);
        check("t4_clr_wins", int'(obs_cnt[1]), 0);

        // Edge mode: two rising edges over a 3-high, 2-low, 2-high pattern.
        load = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; up = 1'b1;
        repeat (3) @(negedge clk);
        up = 1'b0;
        repeat (2) @(negedge clk);
        up = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_edge_count", int'(obs_cnt[2]), 2);
        check("t5_edge_count_m6", int'(obs_cnt[3]), 2);
        #1 n_rst = 1'b0;
        #1 check_reset_state("t5_async");
        #1 n_rst = 1'b1;
        up = 1'b0;

        // Randomized traffic, including occasional mid-run resets.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            clr  = ($urandom_range(0, 99) < 3);
            load = ($urandom_range(0, 99) < 8);
            lv   = 3'($urandom);
            up   = 1'($urandom);
            dn   = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #1 n_rst = 1'b0;
                #1 check_reset_state("rand_reset");
                #1 n_rst = 1'b1;
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
